// File: rtl/dff_load_arbiter.sv
// Four-requester arbiter that turns each grant into one clk_en pulse for a shared 8-bit register.
// Optional macro DFF_ARB_RR_EN selects round-robin arbitration; default is fixed priority (req[0] highest).
module dff_load_arbiter #(
    parameter int unsigned GAP = 2
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic        clk_en,
    output logic [7:0]  Din,
    output logic [3:0]  ack,
    output logic [1:0]  owner,
    output logic        owner_vld,
    output logic        busy
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 2;
    localparam int unsigned CW   = 4;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_GAP} state_e;

    state_e          state_q, state_d;
    logic            clk_en_q, clk_en_d;
    logic [DW-1:0]   din_q, din_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel_c;
    logic            sel_found_c;
`ifdef DFF_ARB_RR_EN
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   idx_c;
`endif

    // Winner selection; only consumed in IDLE.
    always_comb begin
        sel_c       = '0;
        sel_found_c = 1'b0;
`ifdef DFF_ARB_RR_EN
        idx_c       = rr_q;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx_c = IW'(rr_q + IW'(k));
            if (!sel_found_c && req[idx_c]) begin
                sel_c       = idx_c;
                sel_found_c = 1'b1;
            end
        end
`else
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!sel_found_c && req[IW'(k)]) begin
                sel_c       = IW'(k);
                sel_found_c = 1'b1;
            end
        end
`endif
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        clk_en_d    = 1'b0;
        din_d       = din_q;
        ack_d       = '0;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
`ifdef DFF_ARB_RR_EN
        rr_d        = rr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sel_found_c) begin
                    state_d  = S_LOAD;
                    win_d    = sel_c;
                    din_d    = req_data[{sel_c, 3'b000} +: DW];
                    clk_en_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d     = S_ACK;
                ack_d       = NREQ'(1) << win_q;
                owner_d     = win_q;
                owner_vld_d = 1'b1;
`ifdef DFF_ARB_RR_EN
                rr_d        = IW'(win_q + 1'b1);
`endif
            end
            S_ACK: begin
                if (GAP > 0) begin
                    state_d = S_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = CW'(cnt_q - 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_en_q    <= 1'b0;
            din_q       <= '0;
            ack_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            win_q       <= '0;
            cnt_q       <= '0;
`ifdef DFF_ARB_RR_EN
            rr_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            din_q       <= din_d;
            ack_q       <= ack_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
`ifdef DFF_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign clk_en    = clk_en_q;
    assign Din       = din_q;
    assign ack       = ack_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dff_load_arbiter.sv
// Scoreboard bench for dff_load_arbiter: a transaction-level model predicts every load and
// acknowledge; a negedge monitor compares. A second instance with GAP=0 checks back-to-back spacing.
module tb_dff_load_arbiter;
    localparam int TB_GAP = 2;

    typedef struct {
        int         cyc;
        int         w;
        logic [7:0] data;
    } item_t;

    logic        Clk = 1'b0;
    logic        reset;
    logic        rst_g0;
    logic [3:0]  req_v;
    logic [7:0]  data_v [4];
    logic [31:0] req_data;
    logic        clk_en, owner_vld, busy;
    logic [7:0]  Din;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [7:0]  qo;

    logic        clk_en_g0, owner_vld_g0, busy_g0;
    logic [7:0]  Din_g0;
    logic [3:0]  ack_g0;
    logic [1:0]  owner_g0;

    assign req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};

    dff_load_arbiter #(.GAP(TB_GAP)) u_dut (
        .Clk(Clk), .reset(reset), .req(req_v), .req_data(req_data),
        .clk_en(clk_en), .Din(Din), .ack(ack), .owner(owner),
        .owner_vld(owner_vld), .busy(busy)
    );

    dff_load_arbiter #(.GAP(0)) u_dut_g0 (
        .Clk(Clk), .reset(rst_g0), .req(4'b0001), .req_data(32'h0000_005A),
        .clk_en(clk_en_g0), .Din(Din_g0), .ack(ack_g0), .owner(owner_g0),
        .owner_vld(owner_vld_g0), .busy(busy_g0)
    );

    always #5 Clk = ~Clk;

    // Shared register the arbiter feeds.
    always @(posedge Clk) if (clk_en) qo <= Din;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         next_arb, rr_m, busy_from, busy_to, m_owner;
    logic [7:0] m_din;
    bit         m_vld;
    int         drop_at [4];
    logic [3:0] hold_mask;
    bit         gen_en;
    item_t      load_q[$];
    item_t      ack_q[$];
    int         log_din[$];
    int         log_cyc[$];
    int         ack3_cnt;
    int         g0_last = -1;
    int         g0_pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int ptr);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (ptr + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_model();
        load_q.delete();
        ack_q.delete();
        next_arb  = 0;
        rr_m      = 0;
        busy_from = 1;
        busy_to   = 0;
        m_owner   = 0;
        m_din     = 8'h00;
        m_vld     = 1'b0;
        for (int i = 0; i < 4; i++) drop_at[i] = -1;
    endtask

    // One clock: model arbitration at the edge, then requester behaviour 1 time unit later.
    task automatic step();
        int    w;
        item_t it;
        bit    dropped;
        @(posedge Clk);
        cyc++;
        if (!reset && cyc >= next_arb && req_v != 4'b0000) begin
            w       = pick(req_v, rr_m);
            it.cyc  = cyc;
            it.w    = w;
            it.data = data_v[w];
            load_q.push_back(it);
            next_arb   = cyc + 3 + TB_GAP;
            busy_from  = cyc;
            busy_to    = cyc + 1 + TB_GAP;
            drop_at[w] = cyc + 2;
`ifdef DFF_ARB_RR_EN
            rr_m = (w + 1) % 4;
`endif
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            dropped = 1'b0;
            if (drop_at[i] == cyc) begin
                drop_at[i] = -1;
                dropped    = 1'b1;
                if (!hold_mask[i]) req_v[i] = 1'b0;
            end
            if (gen_en && !dropped && !req_v[i] && $urandom_range(0, 3) == 0) begin
                data_v[i] = 8'($urandom);
                req_v[i]  = 1'b1;
            end
        end
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_v     = 4'b0000;
        hold_mask = 4'b0000;
        clear_model();
        step();
        step();
        reset = 1'b0;
        log_din.delete();
        log_cyc.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT is due to present a load or an ack.
    item_t      mit;
    bit         exp_en;
    logic [3:0] exp_ack;
    always @(negedge Clk) begin
        while (load_q.size() > 0 && load_q[0].cyc < cyc) void'(load_q.pop_front());
        exp_en = (load_q.size() > 0 && load_q[0].cyc == cyc);
        chk("clk_en", int'(clk_en), int'(exp_en));
        if (clk_en) begin
            log_din.push_back(int'(Din));
            log_cyc.push_back(cyc);
        end
        if (exp_en) begin
            mit     = load_q.pop_front();
            m_din   = mit.data;
            mit.cyc = cyc + 1;
            ack_q.push_back(mit);
        end
        chk("Din", int'(Din), int'(m_din));
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) void'(ack_q.pop_front());
        exp_ack = 4'b0000;
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
            mit     = ack_q.pop_front();
            exp_ack = 4'(1 << mit.w);
            m_owner = mit.w;
            m_vld   = 1'b1;
            chk("Qo", int'(qo), int'(mit.data));
        end
        chk("ack", int'(ack), int'(exp_ack));
        if (ack[3]) ack3_cnt++;
        chk("owner", int'(owner), m_owner);
        chk("owner_vld", int'(owner_vld), int'(m_vld));
        chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
    end

    // GAP=0 instance with req[0] held: pulse every 3 cycles, ack the cycle after.
    always @(negedge Clk) begin
        if (!rst_g0) begin
            chk("g0_ack", int'(ack_g0), (g0_last >= 0 && cyc == g0_last + 1) ? 1 : 0);
            if (clk_en_g0) begin
                if (g0_last >= 0) chk("g0_spacing", cyc - g0_last, 3);
                chk("g0_din", int'(Din_g0), 8'h5A);
                g0_last = cyc;
                g0_pulses++;
            end
        end
    end

    int exp_seq [5];
    bit found;

    initial begin
        reset     = 1'b1;
        rst_g0    = 1'b1;
        req_v     = 4'b0000;
        hold_mask = 4'b0000;
        gen_en    = 1'b0;
        ack3_cnt  = 0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        clear_model();
        repeat (3) step();
        reset  = 1'b0;
        rst_g0 = 1'b0;

        // Idle after reset: monitor expects all outputs quiet.
        repeat (20) step();

        // Single load from requester 1.
        log_din.delete();
        log_cyc.delete();
        data_v[1] = 8'd55;
        req_v     = 4'b0010;
        repeat (10) step();
        chk("single_loads", log_din.size(), 1);
        if (log_din.size() > 0) chk("single_din", log_din[0], 55);

        // Requesters 0 and 3 held high.
        reset_dut();
        data_v[0] = 8'h11;
        data_v[3] = 8'h33;
        hold_mask = 4'b1001;
        req_v     = 4'b1001;
        ack3_cnt  = 0;
        repeat (30) step();
`ifndef DFF_ARB_RR_EN
        chk("fixed_no_ack3", ack3_cnt, 0);
`endif

        // All four held: grant order and spacing.
        reset_dut();
        data_v[0] = 8'd65;
        data_v[1] = 8'd165;
        data_v[2] = 8'd175;
        data_v[3] = 8'd185;
        hold_mask = 4'b1111;
        req_v     = 4'b1111;
        repeat (30) step();
`ifdef DFF_ARB_RR_EN
        exp_seq[0] = 65; exp_seq[1] = 165; exp_seq[2] = 175; exp_seq[3] = 185; exp_seq[4] = 65;
`else
        for (int i = 0; i < 5; i++) exp_seq[i] = 65;
`endif
        chk("all4_enough_loads", int'(log_din.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < log_din.size()) chk("all4_order", log_din[i], exp_seq[i]);
            if (i > 0 && i < log_cyc.size()) chk("all4_spacing", log_cyc[i] - log_cyc[i-1], 3 + TB_GAP);
        end

        // Reset asserted in the LOAD cycle.
        reset_dut();
        data_v[3] = 8'd185;
        req_v     = 4'b1000;
        found     = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (load_q.size() > 0 && load_q[0].cyc == cyc) found = 1'b1;
        end
        chk("midload_reached", int'(found), 1);
        #2;
        chk("midload_din", int'(Din), 185);
        reset = 1'b1;
        clear_model();
        #1;
        chk("midload_clk_en", int'(clk_en), 0);
        chk("midload_ack", int'(ack), 0);
        chk("midload_owner_vld", int'(owner_vld), 0);
        chk("midload_din_reset", int'(Din), 0);
        step();
        reset = 1'b0;
        log_din.delete();
        log_cyc.delete();
        repeat (12) step();
        chk("post_reset_loads", int'(log_din.size() >= 1), 1);
        if (log_din.size() > 0) chk("post_reset_din", log_din[0], 185);

        // Randomized traffic, then drain.
        reset_dut();
        gen_en = 1'b1;
        repeat (400) step();
        gen_en = 1'b0;
        repeat (40) step();
        chk("drain_load_q", load_q.size(), 0);
        chk("drain_ack_q", ack_q.size(), 0);
        chk("drain_req", int'(req_v), 0);
        chk("g0_pulses_enough", int'(g0_pulses >= 50), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
